// File: rtl/hd44780_pkg.sv
// Shared FSM encoding and default phase lengths for the HD44780 bus writer.
package hd44780_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EHIGH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_PAD   = 3'd4
  } state_t;

  // HD44780 write-cycle timing in nanoseconds, plus the system clock period.
  localparam int H4NS_CLK_PERIOD = 20;
  localparam int H4NS_TAS        = 60;
  localparam int H4NS_PWEH       = 440;
  localparam int H4NS_TAH        = 20;
  localparam int H4NS_PAD        = 440;

  // Round a duration up to whole clocks, never below one clock.
  function automatic int ns_to_ticks(input int ns);
    int t;
    t = (ns + H4NS_CLK_PERIOD - 1) / H4NS_CLK_PERIOD;
    return (t < 1) ? 1 : t;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int DEF_TICKS_TAS  = ns_to_ticks(H4NS_TAS);
  localparam int DEF_TICKS_PWEH = ns_to_ticks(H4NS_PWEH);
  localparam int DEF_TICKS_TAH  = ns_to_ticks(H4NS_TAH);
  localparam int DEF_TICKS_PAD  = ns_to_ticks(H4NS_PAD);

endpackage

// File: rtl/hd44780_bus_writer_phase_timer.sv
// Phase down-counter: load a length, count down, flag the final clock of the phase.
module hd44780_phase_timer #(
  parameter int WIDTH = 5
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt;

  // Load on phase entry, otherwise decrement and park at zero.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A phase of N clocks ends on the edge where the count still reads 1.
  assign done = (cnt == WIDTH'(1));

endmodule

// File: rtl/hd44780_bus_writer.sv
// HD44780 write-cycle sequencer: drives RS/data, pulses E, one or two nybbles per request.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | waiting for STB_I, outputs hold last values
// ST_SETUP | RS/data valid, E low (address setup)
// ST_EHIGH | selected E lines high
// ST_HOLD  | E low, RS/data held (hold time)
// ST_PAD   | idle gap before next nybble or completion
module hd44780_bus_writer
  import hd44780_pkg::*;
#(
  parameter int BUS_WIDTH  = 4,
  parameter int NUM_E      = 1,
  parameter int TICKS_TAS  = DEF_TICKS_TAS,
  parameter int TICKS_PWEH = DEF_TICKS_PWEH,
  parameter int TICKS_TAH  = DEF_TICKS_TAH,
  parameter int TICKS_PAD  = DEF_TICKS_PAD
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 STB_I,
  input  logic                 i_rs,
  input  logic [7:0]           i_data,
  input  logic                 i_nyb_only,
  input  logic [NUM_E-1:0]     i_e_sel,
  output logic                 o_busy,
  output logic                 o_ack,
  output logic [BUS_WIDTH-1:0] o_lcd_data,
  output logic                 o_rs,
  output logic [NUM_E-1:0]     o_e
);

  localparam int CW = $clog2(max4(TICKS_TAS, TICKS_PWEH, TICKS_TAH, TICKS_PAD)) + 1;
  localparam logic [CW-1:0] LD_TAS  = CW'(TICKS_TAS);
  localparam logic [CW-1:0] LD_PWEH = CW'(TICKS_PWEH);
  localparam logic [CW-1:0] LD_TAH  = CW'(TICKS_TAH);
  localparam logic [CW-1:0] LD_PAD  = CW'(TICKS_PAD);

  state_t               state_q, state_d;
  logic                 busy_d, ack_d, rs_d;
  logic [BUS_WIDTH-1:0] data_d;
  logic [NUM_E-1:0]     e_d;
  logic                 pend_q, pend_d;
  logic [BUS_WIDTH-1:0] lo_q, lo_d;
  logic [NUM_E-1:0]     sel_q, sel_d;
  logic                 t_load, t_done;
  logic [CW-1:0]        t_val;

  hd44780_phase_timer #(.WIDTH(CW)) u_timer (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  // State and every output are registered together so pins never see input glitches.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q    <= ST_IDLE;
      o_busy     <= 1'b0;
      o_ack      <= 1'b0;
      o_rs       <= 1'b0;
      o_lcd_data <= '0;
      o_e        <= '0;
      pend_q     <= 1'b0;
      lo_q       <= '0;
      sel_q      <= '0;
    end else begin
      state_q    <= state_d;
      o_busy     <= busy_d;
      o_ack      <= ack_d;
      o_rs       <= rs_d;
      o_lcd_data <= data_d;
      o_e        <= e_d;
      pend_q     <= pend_d;
      lo_q       <= lo_d;
      sel_q      <= sel_d;
    end
  end

  // Next-state, next-output and timer-load decisions.
  always_comb begin
    state_d = state_q;
    busy_d  = o_busy;
    ack_d   = 1'b0;
    rs_d    = o_rs;
    data_d  = o_lcd_data;
    e_d     = o_e;
    pend_d  = pend_q;
    lo_d    = lo_q;
    sel_d   = sel_q;
    t_load  = 1'b0;
    t_val   = '0;
    case (state_q)
      ST_IDLE: begin
        if (STB_I) begin
          state_d = ST_SETUP;
          busy_d  = 1'b1;
          rs_d    = i_rs;
          // In 4-bit mode this is the high nybble; in 8-bit mode the full byte.
          data_d  = i_data[7 -: BUS_WIDTH];
          lo_d    = i_data[BUS_WIDTH-1:0];
          pend_d  = (BUS_WIDTH == 4) && !i_nyb_only;
          sel_d   = i_e_sel;
          t_load  = 1'b1;
          t_val   = LD_TAS;
        end
      end
      ST_SETUP: begin
        if (t_done) begin
          state_d = ST_EHIGH;
          e_d     = sel_q;
          t_load  = 1'b1;
          t_val   = LD_PWEH;
        end
      end
      ST_EHIGH: begin
        if (t_done) begin
          state_d = ST_HOLD;
          e_d     = '0;
          t_load  = 1'b1;
          t_val   = LD_TAH;
        end
      end
      ST_HOLD: begin
        if (t_done) begin
          state_d = ST_PAD;
          t_load  = 1'b1;
          t_val   = LD_PAD;
        end
      end
      ST_PAD: begin
        if (t_done) begin
          if (pend_q) begin
            state_d = ST_SETUP;
            data_d  = lo_q;
            pend_d  = 1'b0;
            t_load  = 1'b1;
            t_val   = LD_TAS;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            ack_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hd44780_bus_writer.sv
// Directed bench for hd44780_bus_writer across four parameterisations.
module tb_hd44780_bus_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // a: 8-bit bus, one E
  logic       a_stb = 0, a_rs = 0, a_nyb = 0;
  logic [7:0] a_data = 0;
  logic [0:0] a_sel = 0;
  logic       a_busy, a_ack, a_ors;
  logic [7:0] a_lcd;
  logic [0:0] a_e;
  // b: 4-bit bus, one E
  logic       b_stb = 0, b_rs = 0, b_nyb = 0;
  logic [7:0] b_data = 0;
  logic [0:0] b_sel = 0;
  logic       b_busy, b_ack, b_ors;
  logic [3:0] b_lcd;
  logic [0:0] b_e;
  // c: 8-bit bus, two E
  logic       c_stb = 0, c_rs = 0, c_nyb = 0;
  logic [7:0] c_data = 0;
  logic [1:0] c_sel = 0;
  logic       c_busy, c_ack, c_ors;
  logic [7:0] c_lcd;
  logic [1:0] c_e;
  // d: 8-bit bus, all phases one clock
  logic       d_stb = 0, d_rs = 0, d_nyb = 0;
  logic [7:0] d_data = 0;
  logic [0:0] d_sel = 0;
  logic       d_busy, d_ack, d_ors;
  logic [7:0] d_lcd;
  logic [0:0] d_e;

  hd44780_bus_writer #(.BUS_WIDTH(8), .NUM_E(1)) u_a (
    .CLK_I(clk), .RST_I(rst_n), .STB_I(a_stb), .i_rs(a_rs), .i_data(a_data),
    .i_nyb_only(a_nyb), .i_e_sel(a_sel), .o_busy(a_busy), .o_ack(a_ack),
    .o_lcd_data(a_lcd), .o_rs(a_ors), .o_e(a_e));

  hd44780_bus_writer #(.BUS_WIDTH(4), .NUM_E(1)) u_b (
    .CLK_I(clk), .RST_I(rst_n), .STB_I(b_stb), .i_rs(b_rs), .i_data(b_data),
    .i_nyb_only(b_nyb), .i_e_sel(b_sel), .o_busy(b_busy), .o_ack(b_ack),
    .o_lcd_data(b_lcd), .o_rs(b_ors), .o_e(b_e));

  hd44780_bus_writer #(.BUS_WIDTH(8), .NUM_E(2)) u_c (
    .CLK_I(clk), .RST_I(rst_n), .STB_I(c_stb), .i_rs(c_rs), .i_data(c_data),
    .i_nyb_only(c_nyb), .i_e_sel(c_sel), .o_busy(c_busy), .o_ack(c_ack),
    .o_lcd_data(c_lcd), .o_rs(c_ors), .o_e(c_e));

  hd44780_bus_writer #(.BUS_WIDTH(8), .NUM_E(1), .TICKS_TAS(1), .TICKS_PWEH(1),
                       .TICKS_TAH(1), .TICKS_PAD(1)) u_d (
    .CLK_I(clk), .RST_I(rst_n), .STB_I(d_stb), .i_rs(d_rs), .i_data(d_data),
    .i_nyb_only(d_nyb), .i_e_sel(d_sel), .o_busy(d_busy), .o_ack(d_ack),
    .o_lcd_data(d_lcd), .o_rs(d_ors), .o_e(d_e));

  task automatic test_reset();
    #12;
    total++;
    if ({a_busy, a_ack, a_ors, a_lcd, a_e} !== 11'd0) begin
      bad++; $display("FAIL reset_a got=%h want=0", {a_busy, a_ack, a_ors, a_lcd, a_e});
    end
    total++;
    if ({b_busy, b_ack, b_ors, b_lcd, b_e} !== 7'd0) begin
      bad++; $display("FAIL reset_b got=%h want=0", {b_busy, b_ack, b_ors, b_lcd, b_e});
    end
    total++;
    if ({c_busy, c_ack, c_ors, c_lcd, c_e} !== 12'd0) begin
      bad++; $display("FAIL reset_c got=%h want=0", {c_busy, c_ack, c_ors, c_lcd, c_e});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({d_busy, d_ack, d_e} !== 3'd0) begin
      bad++; $display("FAIL reset_idle_d got=%b want=000", {d_busy, d_ack, d_e});
    end
  endtask

  // 8-bit single transfer; also used with sel=0 for the no-pulse case
  task automatic test_8bit(input logic [0:0] sel);
    logic [0:0] exp_e;
    @(negedge clk);
    a_stb = 1; a_rs = 1; a_data = 8'hA5; a_nyb = 0; a_sel = sel;
    @(posedge clk); #1;
    a_stb = 0;
    for (int j = 0; j <= 52; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      exp_e = (j >= 3 && j <= 24) ? sel : 1'b0;
      total++;
      if (a_e !== exp_e) begin bad++; $display("FAIL e8 j=%0d got=%b want=%b", j, a_e, exp_e); end
      total++;
      if (a_ack !== (j == 48)) begin bad++; $display("FAIL ack8 j=%0d got=%b want=%b", j, a_ack, (j == 48)); end
      total++;
      if (a_busy !== (j < 48)) begin bad++; $display("FAIL busy8 j=%0d got=%b want=%b", j, a_busy, (j < 48)); end
      if (j < 48) begin
        total++;
        if (a_lcd !== 8'hA5 || a_ors !== 1'b1) begin
          bad++; $display("FAIL data8 j=%0d got=%h/%b want=a5/1", j, a_lcd, a_ors);
        end
      end
    end
  endtask

  task automatic test_4bit();
    logic [3:0] exp_d;
    logic       exp_e;
    @(negedge clk);
    b_stb = 1; b_rs = 0; b_data = 8'h3C; b_nyb = 0; b_sel = 1;
    @(posedge clk); #1;
    b_stb = 0;
    for (int j = 0; j <= 100; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      exp_e = (j >= 3 && j <= 24) || (j >= 51 && j <= 72);
      exp_d = (j < 48) ? 4'h3 : 4'hC;
      total++;
      if (b_e[0] !== exp_e) begin bad++; $display("FAIL e4 j=%0d got=%b want=%b", j, b_e, exp_e); end
      total++;
      if (b_ack !== (j == 96)) begin bad++; $display("FAIL ack4 j=%0d got=%b want=%b", j, b_ack, (j == 96)); end
      total++;
      if (b_busy !== (j < 96)) begin bad++; $display("FAIL busy4 j=%0d got=%b want=%b", j, b_busy, (j < 96)); end
      if (j < 96) begin
        total++;
        if (b_lcd !== exp_d || b_ors !== 1'b0) begin
          bad++; $display("FAIL data4 j=%0d got=%h/%b want=%h/0", j, b_lcd, b_ors, exp_d);
        end
      end
    end
  endtask

  task automatic test_nyb_only();
    logic exp_e;
    @(negedge clk);
    b_stb = 1; b_rs = 0; b_data = 8'h30; b_nyb = 1; b_sel = 1;
    @(posedge clk); #1;
    b_stb = 0;
    for (int j = 0; j <= 70; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      exp_e = (j >= 3 && j <= 24);
      total++;
      if (b_e[0] !== exp_e) begin bad++; $display("FAIL enyb j=%0d got=%b want=%b", j, b_e, exp_e); end
      total++;
      if (b_ack !== (j == 48)) begin bad++; $display("FAIL acknyb j=%0d got=%b want=%b", j, b_ack, (j == 48)); end
      total++;
      if (b_busy !== (j < 48)) begin bad++; $display("FAIL busynyb j=%0d got=%b want=%b", j, b_busy, (j < 48)); end
      if (j < 48) begin
        total++;
        if (b_lcd !== 4'h3) begin bad++; $display("FAIL datanyb j=%0d got=%h want=3", j, b_lcd); end
      end
    end
    b_nyb = 0;
  endtask

  task automatic test_dual_enable();
    logic [1:0] exp_e;
    @(negedge clk);
    c_stb = 1; c_rs = 1; c_data = 8'h12; c_sel = 2'b10;
    @(posedge clk); #1;
    c_stb = 0;
    for (int j = 0; j <= 52; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      exp_e = (j >= 3 && j <= 24) ? 2'b10 : 2'b00;
      total++;
      if (c_e !== exp_e) begin bad++; $display("FAIL edual j=%0d got=%b want=%b", j, c_e, exp_e); end
      total++;
      if (c_lcd === 8'hFF) begin bad++; $display("FAIL ignored_stb j=%0d got=%h want=not ff", j, c_lcd); end
      total++;
      if (c_ack !== (j == 48)) begin bad++; $display("FAIL ackdual j=%0d got=%b want=%b", j, c_ack, (j == 48)); end
      if (j < 48) begin
        total++;
        if (c_lcd !== 8'h12) begin bad++; $display("FAIL datadual j=%0d got=%h want=12", j, c_lcd); end
      end
      // strobe with a different byte lands on edge k+10 while busy
      if (j == 9) begin c_stb = 1; c_data = 8'hFF; c_sel = 2'b01; end
      if (j == 10) begin c_stb = 0; c_data = 8'h12; c_sel = 2'b10; end
    end
  endtask

  task automatic test_reset_abort();
    logic exp_e;
    @(negedge clk);
    a_stb = 1; a_rs = 1; a_data = 8'h5A; a_sel = 1;
    @(posedge clk); #1;
    a_stb = 0;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (a_e !== 1'b1) begin bad++; $display("FAIL e_before_rst got=%b want=1", a_e); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (a_e !== 1'b0 || a_busy !== 1'b0 || a_ack !== 1'b0) begin
      bad++; $display("FAIL async_rst got=e%b busy%b ack%b want=000", a_e, a_busy, a_ack);
    end
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      total++;
      if (a_ack !== 1'b0 || a_busy !== 1'b0) begin
        bad++; $display("FAIL rst_hold j=%0d got=ack%b busy%b want=00", j, a_ack, a_busy);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    a_stb = 1; a_rs = 0; a_data = 8'h66; a_sel = 1;
    @(posedge clk); #1;
    a_stb = 0;
    for (int j = 0; j <= 50; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      exp_e = (j >= 3 && j <= 24);
      total++;
      if (a_e[0] !== exp_e) begin bad++; $display("FAIL e_post j=%0d got=%b want=%b", j, a_e, exp_e); end
      total++;
      if (a_ack !== (j == 48)) begin bad++; $display("FAIL ack_post j=%0d got=%b want=%b", j, a_ack, (j == 48)); end
      if (j < 48) begin
        total++;
        if (a_lcd !== 8'h66 || a_ors !== 1'b0) begin
          bad++; $display("FAIL data_post j=%0d got=%h/%b want=66/0", j, a_lcd, a_ors);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_e, exp_ack, exp_busy;
    @(negedge clk);
    d_stb = 1; d_rs = 1; d_data = 8'h81; d_sel = 1;
    @(posedge clk); #1;
    for (int j = 0; j <= 27; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      if (j <= 24) begin
        exp_e    = (j % 5 == 1);
        exp_ack  = (j % 5 == 4);
        exp_busy = (j % 5 != 4);
      end else begin
        exp_e = 0; exp_ack = 0; exp_busy = 0;
      end
      total++;
      if (d_e[0] !== exp_e) begin bad++; $display("FAIL e_b2b j=%0d got=%b want=%b", j, d_e, exp_e); end
      total++;
      if (d_ack !== exp_ack) begin bad++; $display("FAIL ack_b2b j=%0d got=%b want=%b", j, d_ack, exp_ack); end
      total++;
      if (d_busy !== exp_busy) begin bad++; $display("FAIL busy_b2b j=%0d got=%b want=%b", j, d_busy, exp_busy); end
      if (j <= 23) begin
        total++;
        if (d_lcd !== 8'h81 || d_ors !== 1'b1) begin
          bad++; $display("FAIL data_b2b j=%0d got=%h/%b want=81/1", j, d_lcd, d_ors);
        end
      end
      if (j == 20) d_stb = 0;
    end
  endtask

  initial begin
    test_reset();
    test_8bit(1'b1);
    test_8bit(1'b0);
    test_4bit();
    test_nyb_only();
    test_dual_enable();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
